uart_rx_fifo: RTL

- User-project UART receiver that consumes the 8N1 serial stream driven by the bench UART onto mprj_io[5].
- Stream is driven by the bench on a tx_start/tx_data request, e.g. byte 0x0F.
- Block oversamples the line, validates start/stop bits, and pushes good bytes into a show-ahead FIFO.
- Firmware pops bytes over a simple read strobe; error flags and an interrupt go to the Wishbone register wrapper.

---
 rtl/uart_rx_fifo_pkg.sv | 34 +++
 rtl/uart_rx_fifo_if.sv | 45 ++++
 rtl/uart_sync_fifo.sv | 71 +++++++
 rtl/uart_rx_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package   : uart_pkg
// Purpose   : Shared types and constants for the UART receive path: FSM state
//             encoding, frame geometry, idle line level and divisor clamping.
//             UART_RX_PARITY_EN adds the PARITY state to the encoding.
// Revision  : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Idle (mark) level of the serial line; also the stop-bit level.
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_BREAK  = 3'd4
  } rx_state_t;

  // Divisors below the floor leave too few clocks to locate mid-bit.
  function automatic int unsigned clamp_div(input int unsigned div,
                                            input int unsigned min_div);
    return (div < min_div) ? min_div : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_rx_fifo_if
// Purpose   : Firmware-facing side of the UART receiver: pop/clear strobes in,
//             head byte, FIFO status, sticky errors and interrupt out.
//             UART_RX_PARITY_EN adds parity_err_o.
// Revision  : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if;
  import uart_pkg::*;

  logic                 rd_en_i;
  logic                 clear_err_i;
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_valid_o;
  logic                 fifo_full_o;
  logic                 frame_err_o;
  logic                 overrun_o;
  logic                 irq_o;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err_o;
`endif

  // Receiver side
  modport slave (
    input  rd_en_i, clear_err_i,
    output rx_data_o, rx_valid_o, fifo_full_o, frame_err_o, overrun_o,
`ifdef UART_RX_PARITY_EN
    output parity_err_o,
`endif
    output irq_o
  );

  // Firmware / register-wrapper side
  modport master (
    output rd_en_i, clear_err_i,
    input  rx_data_o, rx_valid_o, fifo_full_o, frame_err_o, overrun_o,
`ifdef UART_RX_PARITY_EN
    input  parity_err_o,
`endif
    input  irq_o
  );

endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module    : uart_sync_fifo
// Purpose   : Single-clock show-ahead FIFO. Head entry is always on rdata_o
//             (zero when empty). Pop on empty is ignored; push on full is
//             accepted only when a pop frees a slot in the same cycle.
// Revision  : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_i,
  input  wire logic                   push_i,
  input  wire logic [WIDTH-1:0]       wdata_i,
  input  wire logic                   pop_i,
  output logic      [WIDTH-1:0]       rdata_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic      [$clog2(DEPTH):0] count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic w_do_pop;
  logic w_do_push;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array: written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module    : uart_rx_fifo
// Purpose   : Oversampling 8N1 UART receiver feeding a show-ahead FIFO, with
//             sticky frame/overrun flags and a registered interrupt.
//             Optional macro UART_RX_PARITY_EN: adds an even-parity bit after
//             bit 7 and a sticky parity_err_o flag.
// Revision  : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int DIV_MIN    = 4
) (
  input  wire logic             wb_clk_i,
  input  wire logic             wb_rst_i,
  input  wire logic             rx_i,
  input  wire logic [DIV_W-1:0] clk_div_i,
  uart_rx_fifo_if.slave         bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]           sync_q;
  logic                 prev_q;
  rx_state_t            state_q;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 push_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 irq_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q;
  logic                 parity_err_q;
`endif

  logic                 w_line;
  logic                 w_fall;
  logic [DIV_W-1:0]     w_div;
  logic [DATA_BITS-1:0] w_rdata;
  logic                 w_empty;
  logic                 w_full;
  logic [CNT_W-1:0]     w_count;
  logic                 w_drop;

  assign w_line = sync_q[1];
  assign w_fall = (prev_q == IDLE_LEVEL) && (w_line != IDLE_LEVEL);
  assign w_div  = DIV_W'(clamp_div(32'(clk_div_i), DIV_MIN));
  // A push is lost only when the FIFO is full and no pop frees a slot.
  assign w_drop = push_q && (w_count == CNT_W'(FIFO_DEPTH))
                  && !(bus.rd_en_i && !w_empty);

  // Two-flop synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q <= {2{IDLE_LEVEL}};
      prev_q <= IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= sync_q[1];
    end
  end

  // Receive FSM: mid-bit sampling, byte assembly, push strobe, frame error.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      data_q      <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      // Clear first so a same-cycle set below takes precedence.
      if (bus.clear_err_i) begin
        frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
      case (state_q)
        S_IDLE: begin
          if (w_fall) begin
            state_q <= S_START;
            div_q   <= w_div;
            cnt_q   <= (w_div >> 1) - DIV_W'(1);
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (w_line != IDLE_LEVEL) begin
              state_q   <= S_DATA;
              cnt_q     <= div_q - DIV_W'(1);
              bit_idx_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            data_q[bit_idx_q] <= w_line;
            cnt_q             <= div_q - DIV_W'(1);
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q == '0) begin
            par_bad_q <= (w_line != ^data_q);
            if (w_line != ^data_q) begin
              parity_err_q <= 1'b1;
            end
            cnt_q   <= div_q - DIV_W'(1);
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == '0) begin
            if (w_line == IDLE_LEVEL) begin
`ifdef UART_RX_PARITY_EN
              push_q <= !par_bad_q;
`else
              push_q <= 1'b1;
`endif
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q - DIV_W'(1);
          end
        end
        S_BREAK: begin
          if (w_line == IDLE_LEVEL) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push_q),
    .wdata_i (data_q),
    .pop_i   (bus.rd_en_i),
    .rdata_o (w_rdata),
    .empty_o (w_empty),
    .full_o  (w_full),
    .count_o (w_count)
  );

  // Sticky overrun: set by a dropped push, set wins over clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      overrun_q <= 1'b0;
    end else if (w_drop) begin
      overrun_q <= 1'b1;
    end else if (bus.clear_err_i) begin
      overrun_q <= 1'b0;
    end
  end

  // Registered interrupt, one cycle behind its sources.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_q <= 1'b0;
    end else begin
`ifdef UART_RX_PARITY_EN
      irq_q <= !w_empty || frame_err_q || overrun_q || parity_err_q;
`else
      irq_q <= !w_empty || frame_err_q || overrun_q;
`endif
    end
  end

  assign bus.rx_data_o   = w_rdata;
  assign bus.rx_valid_o  = !w_empty;
  assign bus.fifo_full_o = w_full;
  assign bus.frame_err_o = frame_err_q;
  assign bus.overrun_o   = overrun_q;
  assign bus.irq_o       = irq_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err_o = parity_err_q;
`endif

endmodule
`default_nettype wire
